// File: rtl/sha_mem_arbiter.sv
// Round-robin read arbiter: NUM_CH channel cores share one memory read port.
// Grants feed a registered issue stage. A channel-ID tag FIFO routes the
// in-order memory responses back to the channel that asked for them.
module sha_mem_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            req_vld,
    input  logic [NUM_CH*ADDR_W-1:0]     req_addr,
    output logic [NUM_CH-1:0]            req_rdy,
    output logic [NUM_CH-1:0]            rsp_vld,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         mem_addr_vld,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_rdy,
    input  logic                         mem_data_vld,
    input  logic [DATA_W-1:0]            mem_data,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         err_unexp
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OW = $clog2(MAX_OUT+1);
    localparam int FW = $clog2(MAX_OUT);

    logic [CW-1:0] ptr;
    logic [CW-1:0] gnt_idx;
    logic          found;
    logic          can_issue;
    logic          grant;
    logic          pop;
    logic [CW-1:0] tag_mem [MAX_OUT];
    logic [FW-1:0] wr_ptr;
    logic [FW-1:0] rd_ptr;

    // Slot accounting uses the registered count only; a same-cycle pop frees
    // nothing until the next cycle. rst_n gating keeps req_rdy low in reset.
    assign can_issue = rst_n && (!mem_addr_vld || mem_rdy) && (outstanding < OW'(MAX_OUT));
    assign grant     = can_issue && found;
    assign pop       = mem_data_vld && (outstanding != '0);

    // Find the first requesting channel at or after ptr, wrapping mod NUM_CH.
    always_comb begin
        logic [CW:0] s;
        found   = 1'b0;
        gnt_idx = '0;
        s       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s = {1'b0, ptr} + (CW+1)'(i);
            if (s >= (CW+1)'(NUM_CH)) s = s - (CW+1)'(NUM_CH);
            if (!found && req_vld[s[CW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = s[CW-1:0];
            end
        end
        req_rdy = grant ? (NUM_CH'(1) << gnt_idx) : '0;
    end

    // Issue register and priority pointer; hold under memory backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            mem_addr_vld <= 1'b0;
            mem_addr     <= '0;
        end else if (grant) begin
            ptr          <= (gnt_idx == CW'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
            mem_addr_vld <= 1'b1;
            mem_addr     <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        end else if (mem_rdy) begin
            mem_addr_vld <= 1'b0;
        end
    end

    // Tag storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (grant) tag_mem[wr_ptr] <= gnt_idx;
    end

    // FIFO pointers and in-flight count; occupancy equals outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (grant) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({grant, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Steer responses to the tagged channel; flag responses nobody asked for.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld   <= '0;
            rsp_data  <= '0;
            err_unexp <= 1'b0;
        end else begin
            rsp_vld <= pop ? (NUM_CH'(1) << tag_mem[rd_ptr]) : '0;
            if (pop) rsp_data <= mem_data;
            if (mem_data_vld && (outstanding == '0)) err_unexp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Directed bench for sha_mem_arbiter with a 1-cycle echo memory model that
// can be told to withhold responses.
module tb_sha_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_vld;
    logic [127:0] req_addr;
    logic [3:0]   req_rdy;
    logic [3:0]   rsp_vld;
    logic [31:0]  rsp_data;
    logic         mem_addr_vld;
    logic [31:0]  mem_addr;
    logic         mem_rdy;
    logic         mem_data_vld;
    logic [31:0]  mem_data;
    logic [2:0]   outstanding;
    logic         err_unexp;

    int           checks = 0;
    int           errors = 0;
    logic         echo;
    logic [31:0]  pend[$];

    sha_mem_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .MAX_OUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_addr(req_addr),
        .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
        .mem_addr_vld(mem_addr_vld), .mem_addr(mem_addr), .mem_rdy(mem_rdy),
        .mem_data_vld(mem_data_vld), .mem_data(mem_data),
        .outstanding(outstanding), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] echo_f(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic logic [3:0] onehot(input int k);
        return 4'b0001 << k;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the memory model records accepted addresses and,
    // in echo mode, answers one per cycle on the cycle after acceptance.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = mem_addr_vld && mem_rdy;
        a   = mem_addr;
        @(posedge clk);
        #1;
        mem_data_vld = 1'b0;
        if (acc) pend.push_back(a);
        if (echo && pend.size() > 0) begin
            mem_data_vld = 1'b1;
            mem_data     = echo_f(pend.pop_front());
        end
    endtask

    task automatic set_addr(input int ch, input logic [31:0] a);
        req_addr[ch*32 +: 32] = a;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_vld = 4'b0;
        mem_data_vld = 1'b0;
        pend.delete();
        tick();
        tick();
        pend.delete();
        mem_data_vld = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_vld = 4'hF; req_addr = '0; mem_rdy = 1'b1;
        mem_data_vld = 1'b0; mem_data = '0; echo = 1'b1;
        #2;
        // Reset state
        check("rst_req_rdy", req_rdy, 4'b0);
        check("rst_mem_addr_vld", mem_addr_vld, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rsp_vld", rsp_vld, 4'b0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_outstanding", outstanding, 3'd0);
        check("rst_err", err_unexp, 1'b0);
        apply_reset();

        // Single request, channel 0, address 0x10
        req_vld = 4'b0001; set_addr(0, 32'h10);
        #1 check("t1_req_rdy_T", req_rdy, 4'b0001);
        tick(); req_vld = 4'b0;
        #1 check("t1_vld_T1", mem_addr_vld, 1'b1);
        check("t1_addr_T1", mem_addr, 32'h10);
        check("t1_out_T1", outstanding, 3'd1);
        tick();
        #1 check("t1_rsp_T2", rsp_vld, 4'b0);
        tick();
        #1 check("t1_rsp_T3", rsp_vld, 4'b0001);
        check("t1_data_T3", rsp_data, 32'h13121110);
        check("t1_out_T3", outstanding, 3'd0);

        // All channels requesting continuously
        apply_reset();
        set_addr(0, 32'h20); set_addr(1, 32'h30); set_addr(2, 32'h40); set_addr(3, 32'h50);
        for (int k = 0; k < 11; k++) begin
            req_vld = (k < 8) ? 4'hF : 4'h0;
            #1 check($sformatf("rr_gnt_%0d", k), req_rdy, (k < 8) ? onehot(k % 4) : 4'b0);
            if (k >= 3) begin
                check($sformatf("rr_rsp_%0d", k), rsp_vld, onehot((k - 3) % 4));
                check($sformatf("rr_data_%0d", k), rsp_data,
                      echo_f(32'h20 + 32'h10 * ((k - 3) % 4)));
            end
            tick();
        end
        #1 check("rr_out_end", outstanding, 3'd0);
        check("rr_rsp_end", rsp_vld, 4'b0);

        // Backpressure: mem_rdy low for 5 cycles after the first grant
        set_addr(0, 32'h60); set_addr(1, 32'h70);
        req_vld = 4'b0011; mem_rdy = 1'b0;
        #1 check("bp_gnt0", req_rdy, 4'b0001);
        tick(); req_vld = 4'b0010;
        for (int j = 0; j < 5; j++) begin
            #1 check($sformatf("bp_vld_%0d", j), mem_addr_vld, 1'b1);
            check($sformatf("bp_addr_%0d", j), mem_addr, 32'h60);
            check($sformatf("bp_nogrant_%0d", j), req_rdy, 4'b0);
            tick();
        end
        mem_rdy = 1'b1;
        #1 check("bp_resume", req_rdy, 4'b0010);
        tick(); req_vld = 4'b0;
        #1 check("bp_addr2", mem_addr, 32'h70);
        check("bp_vld2", mem_addr_vld, 1'b1);
        tick();
        #1 check("bp_rsp0", rsp_vld, 4'b0001);
        check("bp_data0", rsp_data, 32'h63626160);
        tick();
        #1 check("bp_rsp1", rsp_vld, 4'b0010);
        check("bp_data1", rsp_data, 32'h73727170);

        // MAX_OUT limit with responses withheld
        apply_reset();
        echo = 1'b0; req_vld = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("mo_gnt_%0d", k), req_rdy, onehot(k));
            tick();
        end
        #1 check("mo_out4", outstanding, 3'd4);
        check("mo_stall0", req_rdy, 4'b0);
        tick();
        #1 check("mo_stall1", req_rdy, 4'b0);
        mem_data_vld = 1'b1; mem_data = echo_f(pend.pop_front());
        #1 check("mo_stall_pop", req_rdy, 4'b0);
        tick();
        #1 check("mo_rsp", rsp_vld, 4'b0001);
        check("mo_rsp_data", rsp_data, 32'h63626160);
        check("mo_out3", outstanding, 3'd3);
        check("mo_regrant", req_rdy, 4'b0001);
        tick();
        req_vld = 4'b0; echo = 1'b1;
        repeat (8) tick();
        #1 check("mo_drained", outstanding, 3'd0);

        // Unexpected response
        check("ue_clear", err_unexp, 1'b0);
        mem_data_vld = 1'b1; mem_data = 32'hDEADBEEF;
        tick();
        #1 check("ue_set", err_unexp, 1'b1);
        check("ue_norsp", rsp_vld, 4'b0);
        check("ue_out", outstanding, 3'd0);
        tick(); tick();
        #1 check("ue_sticky", err_unexp, 1'b1);

        // Reset with 3 requests in flight
        echo = 1'b0; req_vld = 4'hF;
        tick(); tick(); tick();
        req_vld = 4'b0;
        #1 check("mr_out3", outstanding, 3'd3);
        req_vld = 4'hF; rst_n = 1'b0;
        #1 check("mr_req_rdy", req_rdy, 4'b0);
        check("mr_vld", mem_addr_vld, 1'b0);
        check("mr_addr", mem_addr, 32'h0);
        check("mr_out", outstanding, 3'd0);
        check("mr_rsp", rsp_vld, 4'b0);
        check("mr_data", rsp_data, 32'h0);
        check("mr_err", err_unexp, 1'b0);
        req_vld = 4'b0;
        tick();
        pend.delete();
        rst_n = 1'b1;
        mem_data_vld = 1'b1; mem_data = 32'h12345678;
        tick();
        #1 check("mr_late_err", err_unexp, 1'b1);
        check("mr_late_out", outstanding, 3'd0);
        req_vld = 4'b1100;
        #1 check("mr_ptr0", req_rdy, 4'b0100);
        tick();
        #1 check("mr_addr_ch2", mem_addr, 32'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
